sq_register_gen: RTL
====================

# sq_register_gen

Parametrised, clocked successor to the gate-level sequence register. Holds the current instruction's order code, quarter code and address bit-10, plus the extend (SQEXT), interrupt-inhibit (INHINT) and interrupt-in-progress (IIP) state. Arbitrates NRUPT prioritised interrupt requests at each instruction fetch, forcing the RUPT code when one is granted. Sits between the write bus and the control-pulse decoder.

## Interface
Parameters:
- OPW, 3, order-code width (SQR16/14/13 generalised)
- QCW, 2, quarter-code width (SQR12/11 generalised)
- NRUPT, 10, number of interrupt request channels; 1..16
- RUPT_CODE, {OPW+QCW+1{1'b1}}, value forced into {op,qc,r10} on an interrupt grant

Ports:
- SIM_CLK  in  1  clock, all state on rising edge
- SIM_RST_n  in  1  asynchronous, active-low reset
- GOJAM  in  1  synchronous restart, clears all state
- NISQ  in  1  next-instruction request pulse
- T12  in  1  end-of-MCT strobe, one cycle
- WL  in  OPW+QCW+1  write bus, {op,qc,r10}
- EXTPLS  in  1  extend pulse
- INKL  in  1  counter-cycle inhibit
- INHLPLS / RELINT  in  1 each  set / clear INHINT
- RELPLS  in  1  clear IIP (RESUME)
- OVNHRP, MNHRPT  in  1 each  overflow / manual interrupt inhibit
- RUPT_REQ  in  NRUPT  level requests, bit 0 highest priority
- RUPT_ACK  out  NRUPT  one-hot grant pulse
- SQ_OP / SQ_QC / SQ_R10  out  OPW / QCW / 1  registered fields
- SQEXT, INHINT, IIP, RPTFRC, NISQL  out  1 each  registered state
- SQ_DEC  out  2**OPW  one-hot order-code decode
- QC_DEC  out  2**QCW  one-hot quarter-code decode

## Operation
- Reset: every register and output is 0; RUPT_ACK is 0; SQ_DEC[0] and QC_DEC[0] are 1.
- NISQL: set by NISQ. Cleared on the load edge and by GOJAM.
- Load edge: T12 & (NISQL | NISQ).
- Grant condition at the load edge: |RUPT_REQ & ~IIP & ~INHINT & ~OVNHRP & ~MNHRPT & ~FUTEXT & ~SQEXT.
- Load with grant:
  - {op,qc,r10} <= RUPT_CODE; RPTFRC <= 1; IIP <= 1; SQEXT <= 0.
  - RUPT_ACK <= lowest set index of RUPT_REQ.
- Load without grant:
  - {op,qc,r10} <= WL; RPTFRC <= 0.
  - SQEXT <= FUTEXT; FUTEXT <= 0.
- FUTEXT is internal. It is set by EXTPLS; EXTPLS on the load edge sets FUTEXT for the next load (set wins over clear).
- INHINT:
  - INHLPLS sets it; RELINT clears it.
  - If both arrive in the same cycle, INHLPLS wins.
- IIP:
  - RELPLS clears it.
  - If RELPLS coincides with a grant, the grant wins (IIP = 1).
- INKL = 1: load edge suppressed (NISQL held), SQ_DEC and QC_DEC forced to all-zero, registers unchanged.
- GOJAM: on the next edge clears SQ fields, SQEXT, FUTEXT, NISQL, IIP, INHINT, RPTFRC and RUPT_ACK. GOJAM takes priority over every other input.

## Timing
- Registered outputs update one SIM_CLK after the load edge.
- SQ_DEC and QC_DEC are combinational from the registered fields (same cycle as the fields).
- RUPT_ACK is high for exactly one cycle, aligned with RPTFRC rising. The requester must drop its request within 2 cycles or it is re-granted after the next RELPLS.
- Requests are sampled only on the load edge. A request dropped before T12 is never acknowledged.
- Asynchronous reset mid-instruction: all state clears immediately. The first load after reset is an ordinary WL load.

## Configuration
- SQ_RUPT_VEC_EN defined:
  - Adds output RUPT_VEC [$clog2(NRUPT)-1:0], reset 0.
  - Loaded with the granted channel index on each grant edge; holds otherwise; cleared by GOJAM.
- Not defined: port absent. No other behaviour differs.

## Test plan
- Plain fetch: NISQ, then T12 with WL=6'b101_10_1 (defaults) -> SQ_OP=5, SQ_QC=2, SQ_R10=1, SQ_DEC[5]=1, QC_DEC[2]=1, RPTFRC=0.
- Extend: EXTPLS, then load WL=0 -> SQEXT=1. Next load with WL=0 -> SQEXT=0.
- Grant priority: RUPT_REQ=10'b0000010100, load -> fields=all-ones, RUPT_ACK=10'b0000000100, IIP=1, RUPT_VEC=2 when enabled.
- Blocking: with IIP=1, INHINT=1 or SQEXT=1, RUPT_REQ=1 at load -> WL loaded, RUPT_ACK=0. RELPLS then a load -> grant.
- Simultaneity: INHLPLS and RELINT in the same cycle -> INHINT=1. RELPLS coinciding with a grant -> IIP=1.
- Restart: GOJAM mid-sequence with NISQL=1, INHINT=1 -> all outputs 0 next cycle. The following T12 without NISQ performs no load.

Source files
------------

// File: rtl/sq_register_gen.sv
// Sequence register: holds {op,qc,r10}, extend/interrupt state, and arbitrates
// prioritised interrupt requests at each load edge. Optional RUPT_VEC output under SQ_RUPT_VEC_EN.
module sq_register_gen #(
   parameter int OPW = 3,
   parameter int QCW = 2,
   parameter int NRUPT = 10,
   parameter logic [OPW+QCW:0] RUPT_CODE = {(OPW+QCW+1){1'b1}}
) (
   input  logic                  SIM_CLK,
   input  logic                  SIM_RST_n,
   input  logic                  GOJAM,
   input  logic                  NISQ,
   input  logic                  T12,
   input  logic [OPW+QCW:0]      WL,
   input  logic                  EXTPLS,
   input  logic                  INKL,
   input  logic                  INHLPLS,
   input  logic                  RELINT,
   input  logic                  RELPLS,
   input  logic                  OVNHRP,
   input  logic                  MNHRPT,
   input  logic [NRUPT-1:0]      RUPT_REQ,
   output logic [NRUPT-1:0]      RUPT_ACK,
   output logic [OPW-1:0]        SQ_OP,
   output logic [QCW-1:0]        SQ_QC,
   output logic                  SQ_R10,
   output logic                  SQEXT,
   output logic                  INHINT,
   output logic                  IIP,
   output logic                  RPTFRC,
   output logic                  NISQL,
`ifdef SQ_RUPT_VEC_EN
   output logic [((NRUPT>1)?$clog2(NRUPT):1)-1:0] RUPT_VEC,
`endif
   output logic [(2**OPW)-1:0]   SQ_DEC,
   output logic [(2**QCW)-1:0]   QC_DEC
);
   localparam int VW = (NRUPT > 1) ? $clog2(NRUPT) : 1;

   typedef struct packed {
      logic [OPW-1:0] op;
      logic [QCW-1:0] qc;
      logic           r10;
   } sq_t;

   sq_t                sq_wl, sq_rupt;
   logic               futext;
   logic               load, grant;
   logic [NRUPT-1:0]   ack_nxt;
   logic [VW-1:0]      idx;

   assign sq_wl   = WL;
   assign sq_rupt = RUPT_CODE;

   // Lowest-index request wins; scanning downward leaves the lowest hit last.
   always_comb begin
      idx     = '0;
      ack_nxt = '0;
      for (int i = NRUPT-1; i >= 0; i--) begin
         if (RUPT_REQ[i]) begin
            idx     = VW'(i);
            ack_nxt = NRUPT'(1) << i;
         end
      end
   end

   always_comb begin
      load  = T12 & (NISQL | NISQ) & ~INKL;
      grant = load & (|RUPT_REQ) & ~IIP & ~INHINT & ~OVNHRP & ~MNHRPT & ~futext & ~SQEXT;
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
         SQ_OP    <= '0;
         SQ_QC    <= '0;
         SQ_R10   <= 1'b0;
         SQEXT    <= 1'b0;
         futext   <= 1'b0;
         INHINT   <= 1'b0;
         IIP      <= 1'b0;
         RPTFRC   <= 1'b0;
         NISQL    <= 1'b0;
         RUPT_ACK <= '0;
`ifdef SQ_RUPT_VEC_EN
         RUPT_VEC <= '0;
`endif
      end else if (GOJAM) begin
         SQ_OP    <= '0;
         SQ_QC    <= '0;
         SQ_R10   <= 1'b0;
         SQEXT    <= 1'b0;
         futext   <= 1'b0;
         INHINT   <= 1'b0;
         IIP      <= 1'b0;
         RPTFRC   <= 1'b0;
         NISQL    <= 1'b0;
         RUPT_ACK <= '0;
`ifdef SQ_RUPT_VEC_EN
         RUPT_VEC <= '0;
`endif
      end else begin
         RUPT_ACK <= grant ? ack_nxt : '0;
         if (load)      NISQL <= 1'b0;
         else if (NISQ) NISQL <= 1'b1;

         if (INHLPLS)     INHINT <= 1'b1;
         else if (RELINT) INHINT <= 1'b0;

         if (grant)       IIP <= 1'b1;
         else if (RELPLS) IIP <= 1'b0;

         // An extend pulse on the load edge arms the following load.
         if (EXTPLS)                futext <= 1'b1;
         else if (load && !grant)   futext <= 1'b0;

         if (load) begin
            RPTFRC <= grant;
            if (grant) begin
               {SQ_OP, SQ_QC, SQ_R10} <= sq_rupt;
               SQEXT <= 1'b0;
            end else begin
               {SQ_OP, SQ_QC, SQ_R10} <= sq_wl;
               SQEXT <= futext;
            end
         end
`ifdef SQ_RUPT_VEC_EN
         if (grant) RUPT_VEC <= idx;
`endif
      end
   end

   // Decoders go dark during counter cycles so no instruction pulses fire.
   always_comb begin
      SQ_DEC = '0;
      QC_DEC = '0;
      if (!INKL) begin
         SQ_DEC[SQ_OP] = 1'b1;
         QC_DEC[SQ_QC] = 1'b1;
      end
   end
endmodule
